// File: rtl/pdp8l_pkg.sv
// pdp8l_pkg: shared states and opcode constants for the PDP-8/L IOP master.
package pdp8l_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HOLD, S_SAMPLE, S_STOP, S_CHECK, S_FIN
  } state_t;
  localparam logic [2:0] IOT_GRP = 3'o6;
  localparam logic [11:0] OP_ION = 12'o6001;
  localparam logic [11:0] OP_IOF = 12'o6002;
  localparam int IOPLEN_DEF = 3;
endpackage

// File: rtl/pdp8l_iop_master.sv
// pdp8l_iop_master: sequences one IOT instruction over the device OR-bus.
module pdp8l_iop_master
  import pdp8l_pkg::*;
#(
  parameter int IOPLEN = IOPLEN_DEF
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        CSTEP,
  input  logic        start,
  input  logic [11:0] opcode,
  input  logic [11:0] acin,
  input  logic [11:0] devtocpu,
  input  logic        AC_CLEAR,
  input  logic        IO_SKIP,
  input  logic        INT_RQST,
  output logic        iopstart,
  output logic        iopstop,
  output logic [11:0] ioopcode,
  output logic [11:0] cputodev,
  output logic        busy,
  output logic        done,
  output logic [11:0] acout,
  output logic        skip,
  output logic        illop,
  output logic        buserr,
  output logic        intreq
);
  state_t state, nxt;
  logic [11:0] op, ac;
  logic [3:0] cnt;
  logic ien, iot, dev, bus;
  assign iot = op[11:9] == IOT_GRP;
  // 600x opcodes are processor-internal and never reach the bus
  assign dev = iot && op[8:3] != 6'd0;
  assign bus = dev && state inside {S_START, S_HOLD, S_SAMPLE, S_STOP, S_CHECK};
  assign iopstart = dev && state == S_START;
  assign iopstop = state == S_STOP;
  assign ioopcode = bus ? op : '0;
  assign cputodev = bus ? ac : '0;
  assign busy = state != S_IDLE;
  assign done = state == S_FIN;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = start ? S_START : S_IDLE;
      S_START:  nxt = !CSTEP ? S_START : dev ? S_HOLD : S_FIN;
      S_HOLD:   nxt = (CSTEP && cnt == 4'(IOPLEN - 1)) ? S_SAMPLE : S_HOLD;
      S_SAMPLE: nxt = CSTEP ? S_STOP : S_SAMPLE;
      S_STOP:   nxt = CSTEP ? S_CHECK : S_STOP;
      S_CHECK:  nxt = CSTEP ? S_FIN : S_CHECK;
      S_FIN:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      op     <= '0;
      ac     <= '0;
      cnt    <= '0;
      ien    <= 1'b0;
      acout  <= '0;
      skip   <= 1'b0;
      illop  <= 1'b0;
      buserr <= 1'b0;
      intreq <= 1'b0;
    end else begin
      state  <= nxt;
      intreq <= INT_RQST && ien;
      case (state)
        S_IDLE: if (start) begin
          op     <= opcode;
          ac     <= acin;
          skip   <= 1'b0;
          illop  <= 1'b0;
          buserr <= 1'b0;
        end
        S_START: begin
          cnt <= '0;
          if (CSTEP && !dev) begin
            acout <= ac;
            illop <= op != OP_ION && op != OP_IOF;
            ien   <= op == OP_ION ? 1'b1 : op == OP_IOF ? 1'b0 : ien;
          end
        end
        S_HOLD: if (CSTEP) cnt <= cnt + 4'd1;
        S_SAMPLE: if (CSTEP) begin
          acout <= (AC_CLEAR ? 12'd0 : ac) | devtocpu;
          skip  <= IO_SKIP;
        end
        S_CHECK: if (CSTEP) buserr <= (devtocpu != 12'd0) || AC_CLEAR || IO_SKIP;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/pdp8l_iop_master.md
PDP8L_IOP_MASTER -- requirements
Module: pdp8l_iop_master

Interface
REQ-001 Parameter IOPLEN, default 3: number of CSTEP-qualified clocks the IOP is held before the device response is sampled (legal 1..15).
REQ-002 CLOCK  input  1  sole clock; all state changes on its rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 CSTEP  input  1  step enable; the state machine advances only on clocks with CSTEP=1.
REQ-005 start  input  1  request to execute one instruction; sampled on any clock.
REQ-006 opcode  input  12  instruction word to execute; latched with start.
REQ-007 acin  input  12  accumulator before the instruction; latched with start.
REQ-008 devtocpu  input  12  OR-bus data from the devices.
REQ-009 AC_CLEAR, IO_SKIP, INT_RQST  input  1 each  device responses (OR-bus) and interrupt request.
REQ-010 iopstart, iopstop  output  1 each  IOP leading-edge and release strobes to the devices.
REQ-011 ioopcode, cputodev  output  12 each  opcode and AC driven to the devices.
REQ-012 busy, done  output  1 each  operation in progress; one-clock completion pulse.
REQ-013 acout  output  12  resulting accumulator, valid from done until the next start.
REQ-014 skip, illop, buserr  output  1 each  result flags, valid with acout.
REQ-015 intreq  output  1  registered INT_RQST AND interrupt-enable.

Function
REQ-016 States SHALL be IDLE, START, HOLD, SAMPLE, STOP, CHECK, FIN.
REQ-017 In IDLE, start=1 SHALL latch opcode and acin, set busy, clear skip/illop/buserr, and go to START on the same clock regardless of CSTEP.
REQ-018 start while busy=1 SHALL be ignored; it is neither queued nor does it alter latched values.
REQ-019 opcode[11:9] != 3'o6 SHALL go START->FIN with illop=1, acout=acin, and no bus strobes.
REQ-020 Opcode 6001 SHALL set the interrupt enable and 6002 SHALL clear it; both go START->FIN with acout=acin and no bus strobes; other 600x opcodes SHALL set illop.
REQ-021 For other IOTs, ioopcode=opcode and cputodev=acin SHALL be driven from START through CHECK, and zero otherwise.
REQ-022 iopstart SHALL be 1 exactly while in START; START->HOLD on the first CSTEP.
REQ-023 HOLD SHALL count IOPLEN CSTEP clocks with a 4-bit counter, then go to SAMPLE.
REQ-024 On the CSTEP in SAMPLE: acout = (AC_CLEAR ? 0 : acin) | devtocpu; skip=IO_SKIP; then go to STOP.
REQ-025 iopstop SHALL be 1 exactly while in STOP; STOP->CHECK on the first CSTEP.
REQ-026 On the CSTEP in CHECK, buserr SHALL be set if devtocpu!=0, AC_CLEAR=1 or IO_SKIP=1 (device failed to release); then go to FIN.
REQ-027 FIN SHALL pulse done for one clock, clear busy, and return to IDLE independent of CSTEP.
REQ-028 intreq SHALL equal the previous clock's INT_RQST AND the interrupt enable; a change in enable SHALL take effect on the clock after FIN.
REQ-029 Minimum IOT latency from start to done SHALL be IOPLEN+5 CSTEP clocks with CSTEP held at 1.

Reset
REQ-030 RESET_N=0 SHALL immediately force IDLE and zero all outputs, the counter, the latched values and the interrupt enable, including mid-operation; no done pulse results.
REQ-031 After RESET_N rises, the first clock SHALL accept start.

Structure
REQ-032 The state enum, the IOT group code 3'o6, the ION/IOF opcodes and the IOPLEN default SHALL live in shared package pdp8l_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the counter is inline.

Verification
REQ-034 IOPLEN=3, CSTEP=1, start, opcode=6036, acin=1234, the device model returns AC_CLEAR=1 and devtocpu=0101 -> acout=0101, skip=0, done at clock 8, one iopstart pulse and one iopstop pulse.
REQ-035 opcode=6041, acin=7777, the device asserts IO_SKIP and leaves devtocpu=0 -> acout=7777, skip=1, buserr=0.
REQ-036 opcode=6001, then INT_RQST=1 -> no strobes, and intreq=1 one clock after FIN; opcode=6002 -> intreq=0.
REQ-037 opcode=1234 -> illop=1, acout=acin, done two clocks after start; and a device model that holds devtocpu=0007 through CHECK -> buserr=1.
REQ-038 With CSTEP toggling 1-of-3 clocks and RESET_N pulsed low during HOLD, the stall timing is correct and the block returns to IDLE with zero outputs, no done, and accepts the next start.
